int_ctrl: RTL
=============

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter: NSRC, 4, number of interrupt sources (2..8).
REQ-002 Parameter: VW, 2, vector width, equal to ceil(log2(NSRC)).
REQ-003 Port: clk  input  1  single system clock, all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: irq_req  input  NSRC  level interrupt lines from sources (e.g. timer INT), held high until cleared by source.
REQ-006 Port: irq_clr  output  NSRC  per-source clear, drives the source's clr input.
REQ-007 Port: mask_we  input  1  write strobe for mask register.
REQ-008 Port: mask_wdata  input  NSRC  new mask value, 1 = source disabled.
REQ-009 Port: cpu_irq  output  1  interrupt request to CPU.
REQ-010 Port: cpu_vector  output  VW  index of source being requested/serviced.
REQ-011 Port: cpu_ack  input  1  CPU accepts request, one-cycle pulse.
REQ-012 Port: cpu_eoi  input  1  CPU end-of-interrupt, one-cycle pulse.
REQ-013 Port: overrun  output  NSRC  sticky flag, edge arrived while same source already pending.
REQ-014 Port: pending  output  NSRC  current pending register.

Function
REQ-015 The block SHALL register irq_req once (irq_q) and detect rising edges as irq_req & ~irq_q.
REQ-016 pending[i] SHALL set on a rising edge of irq_req[i] regardless of mask; masking affects selection only.
REQ-017 A rising edge on source i while pending[i]=1 SHALL set overrun[i]; pending does not count.
REQ-018 A mask_we cycle SHALL load mask from mask_wdata and clear all overrun bits; a simultaneous new overrun SHALL win (bit stays set).
REQ-019 FSM states SHALL be IDLE, REQ, CLEAR, SERVICE.
REQ-020 IDLE: if (pending & ~mask) nonzero, latch the lowest set index into cpu_vector, go to REQ next cycle; otherwise stay.
REQ-021 REQ: cpu_irq=1; cpu_vector held stable; mask changes do not withdraw the request; on cpu_ack clear pending[cpu_vector] and go to CLEAR.
REQ-022 CLEAR: irq_clr[cpu_vector]=1, all other irq_clr bits 0; leave to SERVICE on the first cycle irq_req[cpu_vector] is sampled 0.
REQ-023 SERVICE: cpu_irq=0; on cpu_eoi go to IDLE; no new request is issued (no nesting).
REQ-024 cpu_eoi received in CLEAR SHALL be remembered and cause direct transition CLEAR->IDLE once the source drops.
REQ-025 cpu_ack outside REQ and cpu_eoi in IDLE or REQ SHALL be ignored.
REQ-026 Edges arriving in any state SHALL still set pending/overrun.
REQ-027 A rising edge on pending[cpu_vector] in the same cycle as its ack-clear SHALL leave pending set (set wins).
REQ-028 Latency: edge at cycle N -> pending at N+1 -> cpu_irq at N+2 when IDLE and unmasked.
REQ-029 irq_clr and cpu_irq SHALL be registered outputs, glitch-free.

Reset
REQ-030 On rst_n low: state=IDLE, irq_q=0, pending=0, overrun=0, mask=all ones (all disabled), cpu_irq=0, cpu_vector=0, irq_clr=0.
REQ-031 A source already high at reset release SHALL NOT be seen as an edge (irq_q loads without setting pending for one cycle after release).
REQ-032 Reset mid-service SHALL abandon the interrupt; irq_clr drops immediately.

Structure
REQ-033 Shared package SHALL hold the state encoding (IDLE=0, REQ=1, CLEAR=2, SERVICE=3) and default NSRC/VW constants.
REQ-034 One sub-module prio_enc (combinational lowest-index-first encoder, NSRC in, VW index plus valid out) SHALL be instantiated; all else in int_ctrl.

Verification
REQ-035 Mask=0, pulse irq_req[2] high at cycle 10 -> pending[2] at 11, cpu_irq=1 vector=2 at 12; ack -> irq_clr[2] high until source low, then eoi -> IDLE.
REQ-036 irq_req[1] and [3] rise same cycle -> vector=1 first; after eoi -> vector=3 served.
REQ-037 Mask=4'b0100, edge on source 2 -> no cpu_irq; write mask=0 -> cpu_irq 2 cycles later with vector=2.
REQ-038 Source 0 drops then rises again while pending[0]=1 -> overrun[0]=1; mask_we clears it.
REQ-039 Source holds irq_req high 5 cycles after irq_clr -> irq_clr held 5 cycles; eoi during CLEAR -> IDLE right after drop.
REQ-040 rst_n low during CLEAR with source 1 high -> all outputs 0; after release no pending set until a new edge.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: default sizing and the
// controller state encoding.
package int_ctrl_pkg;

   // Default number of interrupt sources and matching vector width.
   localparam int NSRC_DEF = 4;
   localparam int VW_DEF   = 2;

   // Controller states; encoding is fixed so software-visible debug taps agree.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      CLEAR   = 2'd2,
      SERVICE = 2'd3
   } state_e;

endpackage : int_ctrl_pkg

// File: rtl/prio_enc.sv
// Combinational priority encoder: reports the lowest set index of req.
module prio_enc
   import int_ctrl_pkg::*;
#(
   parameter int NSRC = NSRC_DEF,
   parameter int VW   = VW_DEF
) (
   input  logic [NSRC-1:0] req,
   output logic [VW-1:0]   idx,
   output logic            valid
);

   // Scan from the top down so the lowest set bit is the last one written.
   // NOTE: every output gets a default before the loop, so no latch is inferred.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = VW'(i);
            valid = 1'b1;
         end
      end
   end

endmodule : prio_enc

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-detects level interrupt lines into a pending
// register, presents the lowest unmasked pending source to the CPU, clears
// the source after acknowledge and waits for end-of-interrupt (no nesting).
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int NSRC = NSRC_DEF,
   parameter int VW   = VW_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NSRC-1:0] irq_req,
   output logic [NSRC-1:0] irq_clr,
   input  logic            mask_we,
   input  logic [NSRC-1:0] mask_wdata,
   output logic            cpu_irq,
   output logic [VW-1:0]   cpu_vector,
   input  logic            cpu_ack,
   input  logic            cpu_eoi,
   output logic [NSRC-1:0] overrun,
   output logic [NSRC-1:0] pending
);

   localparam logic [NSRC-1:0] ONE_HOT0 = NSRC'(1);

   // State registers and their next-state values.
   state_e          state_q, state_d;
   logic [NSRC-1:0] irq_q, irq_d;
   logic            armed_q, armed_d;
   logic [NSRC-1:0] pending_q, pending_d;
   logic [NSRC-1:0] overrun_q, overrun_d;
   logic [NSRC-1:0] mask_q, mask_d;
   logic [VW-1:0]   vec_q, vec_d;
   logic            eoi_seen_q, eoi_seen_d;
   logic            cpu_irq_q, cpu_irq_d;
   logic [NSRC-1:0] irq_clr_q, irq_clr_d;

   // Combinational helpers.
   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] ack_clr;
   logic [VW-1:0]   sel_idx;
   logic            sel_valid;
   logic            src_level;

   // Lowest-index-first selection among pending, unmasked sources.
   prio_enc #(
      .NSRC (NSRC),
      .VW   (VW)
   ) u_prio_enc (
      .req   (pending_q & ~mask_q),
      .idx   (sel_idx),
      .valid (sel_valid)
   );

   // Edge detection; the first cycle after reset only primes irq_q so a line
   // that is already high at release is not mistaken for a new edge.
   always_comb begin
      irq_d     = irq_req;
      armed_d   = 1'b1;
      rise      = armed_q ? (irq_req & ~irq_q) : '0;
      src_level = irq_req[vec_q];
   end

   // Controller sequencing: request, clear the source, wait for EOI.
   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      eoi_seen_d = eoi_seen_q;
      ack_clr    = '0;
      unique case (state_q)
         IDLE: begin
            if (sel_valid) begin
               vec_d   = sel_idx;
               state_d = REQ;
            end
         end
         REQ: begin
            // Mask writes and EOI are irrelevant here; only ack moves on.
            if (cpu_ack) begin
               ack_clr    = ONE_HOT0 << vec_q;
               eoi_seen_d = 1'b0;
               state_d    = CLEAR;
            end
         end
         CLEAR: begin
            // An early EOI is remembered so the drop returns straight to IDLE.
            if (cpu_eoi) begin
               eoi_seen_d = 1'b1;
            end
            if (!src_level) begin
               eoi_seen_d = 1'b0;
               state_d    = (eoi_seen_q || cpu_eoi) ? IDLE : SERVICE;
            end
         end
         SERVICE: begin
            if (cpu_eoi) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they leave a flop directly.
   always_comb begin
      cpu_irq_d = (state_d == REQ);
      irq_clr_d = (state_d == CLEAR) ? (ONE_HOT0 << vec_d) : '0;
   end

   // Pending, overrun and mask bookkeeping; a new edge beats any clear.
   always_comb begin
      pending_d = (pending_q & ~ack_clr) | rise;
      overrun_d = (mask_we ? '0 : overrun_q) | (rise & pending_q);
      mask_d    = mask_we ? mask_wdata : mask_q;
   end

   // State register; reset leaves every source masked and nothing in flight.
   // NOTE: sequential state uses non-blocking assignments so all flops update
   // together from values computed in the previous cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         irq_q      <= '0;
         armed_q    <= 1'b0;
         pending_q  <= '0;
         overrun_q  <= '0;
         mask_q     <= '1;
         vec_q      <= '0;
         eoi_seen_q <= 1'b0;
         cpu_irq_q  <= 1'b0;
         irq_clr_q  <= '0;
      end else begin
         state_q    <= state_d;
         irq_q      <= irq_d;
         armed_q    <= armed_d;
         pending_q  <= pending_d;
         overrun_q  <= overrun_d;
         mask_q     <= mask_d;
         vec_q      <= vec_d;
         eoi_seen_q <= eoi_seen_d;
         cpu_irq_q  <= cpu_irq_d;
         irq_clr_q  <= irq_clr_d;
      end
   end

   assign irq_clr    = irq_clr_q;
   assign cpu_irq    = cpu_irq_q;
   assign cpu_vector = vec_q;
   assign overrun    = overrun_q;
   assign pending    = pending_q;

endmodule : int_ctrl
